// File: rtl/psdsqrt_pkg.sv
// Shared constants and width helpers for the psdsqrt square-root block.
// Contents: default radicand width, iteration count and remainder width,
// each as a function of the radicand width.
package psdsqrt_pkg;

  localparam int unsigned NBITSIN_DEF = 32;

  // One result bit per iteration, so the iteration count is half the radicand width.
  function automatic int unsigned iter_count(input int unsigned w);
    return w / 2;
  endfunction

  // The remainder stays within 2*root, so this width cannot overflow for any radicand.
  function automatic int unsigned rem_width(input int unsigned w);
    return w / 2 + 2;
  endfunction

endpackage

// File: rtl/psdsqrt_step.sv
// One iteration of a restoring binary square root.
// The step shifts the next radicand bit pair into the remainder.
// It then tries to subtract {root, 01}.
// If the subtraction does not underflow, the difference is kept and a 1 is appended to the root.
// Otherwise the shifted remainder is kept and a 0 is appended.
// Ports:
//   rem_in   : remainder before this iteration
//   root_in  : partial root before this iteration
//   pair     : next two radicand bits, MSB pair first
//   rem_out  : remainder after this iteration
//   root_out : partial root after this iteration
module psdsqrt_step
  import psdsqrt_pkg::*;
#(
  parameter int unsigned NBITSIN = NBITSIN_DEF
) (
  input  logic [rem_width(NBITSIN)-1:0]  rem_in,
  input  logic [iter_count(NBITSIN)-1:0] root_in,
  input  logic [1:0]                     pair,
  output logic [rem_width(NBITSIN)-1:0]  rem_out,
  output logic [iter_count(NBITSIN)-1:0] root_out
);

  localparam int unsigned N  = iter_count(NBITSIN);
  localparam int unsigned RW = rem_width(NBITSIN);

  // Two guard bits so the shift and compare are evaluated without truncation.
  logic [RW+1:0] rem_sh;
  logic [RW+1:0] trial;
  logic [RW+1:0] diff;
  logic          take;

  // Trial subtract and restore.
  always_comb begin
    rem_sh   = {rem_in, pair};
    trial    = {2'b00, root_in, 2'b01};
    take     = (rem_sh >= trial);
    diff     = rem_sh - trial;
    rem_out  = take ? RW'(diff) : RW'(rem_sh);
    root_out = N'({root_in, take});
  end

endmodule

// File: rtl/psdsqrt.sv
// Sequential floor(sqrt(xin)) for an unsigned radicand.
// Produces one result bit per clock cycle, MSB first.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-high reset
//   start  : pulse; captures xin and launches a computation (aborts any in flight)
//   stop   : pulse; copies the internal root into sqrt
//   xin    : unsigned radicand, NBITSIN bits
//   sqrt   : registered result, NBITSIN/2 bits; changes only on stop or reset
//   done   : (only with PSDSQRT_DONE_EN) high for the one cycle after the last iteration
// Optional feature macro: PSDSQRT_DONE_EN.
module psdsqrt
  import psdsqrt_pkg::*;
#(
  parameter int unsigned NBITSIN = NBITSIN_DEF
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           stop,
  input  logic [NBITSIN-1:0]             xin,
`ifdef PSDSQRT_DONE_EN
  output logic                           done,
`endif
  output logic [iter_count(NBITSIN)-1:0] sqrt
);

  localparam int unsigned N  = iter_count(NBITSIN);
  localparam int unsigned RW = rem_width(NBITSIN);
  localparam int unsigned CW = $clog2(N + 1);

  logic [NBITSIN-1:0] op;
  logic [N-1:0]       root;
  logic [RW-1:0]      rem;
  logic [CW-1:0]      cnt;
  logic [N-1:0]       root_nx;
  logic [RW-1:0]      rem_nx;

  psdsqrt_step #(
    .NBITSIN (NBITSIN)
  ) u_step (
    .rem_in   (rem),
    .root_in  (root),
    .pair     (op[NBITSIN-1 -: 2]),
    .rem_out  (rem_nx),
    .root_out (root_nx)
  );

  // Datapath and output register.
  // The stop load uses the pre-edge root, so a stop that coincides with start reports the previous result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op   <= '0;
      root <= '0;
      rem  <= '0;
      cnt  <= '0;
      sqrt <= '0;
    end else begin
      if (stop) begin
        sqrt <= root;
      end
      if (start) begin
        op   <= xin;
        root <= '0;
        rem  <= '0;
        cnt  <= CW'(N);
      end else if (cnt != '0) begin
        op   <= {op[NBITSIN-3:0], 2'b00};
        root <= root_nx;
        rem  <= rem_nx;
        cnt  <= cnt - CW'(1);
      end
    end
  end

`ifdef PSDSQRT_DONE_EN
  // The last iteration runs while cnt==1; a start on that edge aborts the run, so no pulse is raised.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done <= 1'b0;
    end else begin
      done <= (cnt == CW'(1)) && !start;
    end
  end
`endif

endmodule

// File: tb/tb_psdsqrt.sv
// Self-checking bench for psdsqrt at NBITSIN=32.
// Also exercises done when PSDSQRT_DONE_EN is defined.
module tb_psdsqrt;

  localparam int unsigned W  = 32;
  localparam int unsigned NB = W / 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop  = 1'b0;
  logic [W-1:0]  xin   = '0;
  logic [NB-1:0] sqrt;
`ifdef PSDSQRT_DONE_EN
  logic          done;
`endif

  int passed = 0;
  int total  = 0;

  psdsqrt #(.NBITSIN(W)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .stop  (stop),
    .xin   (xin),
`ifdef PSDSQRT_DONE_EN
    .done  (done),
`endif
    .sqrt  (sqrt)
  );

  always #5 clock = ~clock;

  // Reference: integer square root from a real estimate, corrected to exact floor.
  function automatic logic [NB-1:0] isqrt(input longint unsigned x);
    longint unsigned r;
    r = longint'($rtoi($sqrt(real'(x))));
    while (r * r > x) r = r - 1;
    while ((r + 1) * (r + 1) <= x) r = r + 1;
    return NB'(r);
  endfunction

  // Root after k iterations equals floor(sqrt) of the top 2k radicand bits.
  function automatic logic [NB-1:0] partial_root(input longint unsigned x, input int k);
    if (k == 0) return '0;
    return isqrt(x >> (W - 2 * k));
  endfunction

  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Start pulse; returns just after edge E0.
  task automatic do_start(input logic [W-1:0] x);
    start = 1'b1;
    xin   = x;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
  endtask

  // Full contract: start at E0, stop at E17, then check the result (and done if present).
  task automatic run_full(input string tag, input logic [W-1:0] x);
    do_start(x);
    cycles(15);
`ifdef PSDSQRT_DONE_EN
    check_bit({tag, "_done_early"}, done, 1'b0);
`endif
    cycles(1);
`ifdef PSDSQRT_DONE_EN
    check_bit({tag, "_done_pulse"}, done, 1'b1);
`endif
    do_stop();
`ifdef PSDSQRT_DONE_EN
    check_bit({tag, "_done_drop"}, done, 1'b0);
`endif
    check(tag, sqrt, isqrt(longint'(x)));
  endtask

  initial begin
    logic [W-1:0]   prev;
    logic [W-1:0]   nxt;
    longint unsigned r;

    // Reset state
    cycles(2);
    check("reset_sqrt", sqrt, '0);
`ifdef PSDSQRT_DONE_EN
    check_bit("reset_done", done, 1'b0);
`endif
    reset = 1'b0;
    cycles(1);

    // Directed values
    run_full("x100", 32'd100);
    run_full("x12", 32'd12);
    run_full("x13", 32'd13);
    run_full("x1057", 32'd1057);
    run_full("x4300", 32'd4300);

    // Boundaries
    run_full("x0", 32'd0);
    run_full("x1", 32'd1);
    run_full("xmax", 32'hFFFF_FFFF);
    run_full("xsq_max", 32'hFFFE_0001);
    run_full("xsq_max_m1", 32'hFFFE_0000);

    // Restart at E5: sqrt holds its old value until the later stop.
    run_full("pre_restart", 32'd100);
    do_start(32'd100);
    cycles(4);
    do_start(32'd4300);
    cycles(16);
    check("hold_restart", sqrt, 16'd10);
`ifdef PSDSQRT_DONE_EN
    check_bit("restart_done_pulse", done, 1'b1);
`endif
    do_stop();
    check("restart", sqrt, 16'd65);

`ifdef PSDSQRT_DONE_EN
    // An abort on the final iteration edge must not produce a done pulse.
    do_start(32'd999);
    cycles(15);
    do_start(32'd49);
    check_bit("abort_no_done", done, 1'b0);
    cycles(16);
    check_bit("after_abort_done", done, 1'b1);
    do_stop();
    check("after_abort", sqrt, 16'd7);
`endif

    // Early stop at E8 loads the partial root after 7 iterations.
    do_start(32'hFFFF_FFFF);
    cycles(7);
    do_stop();
    check("early_stop", sqrt, partial_root(64'hFFFF_FFFF, 7));
    cycles(12);

    // Asynchronous reset at E8 of 1057.
    run_full("pre_reset", 32'd4300);
    do_start(32'd1057);
    cycles(7);
    @(posedge clock);
    #2 reset = 1'b1;
    #1 check("reset_async", sqrt, '0);
    @(negedge clock);
    reset = 1'b0;
    cycles(20);
    check("reset_hold", sqrt, '0);
    do_stop();
    check("reset_stop_zero", sqrt, '0);
    run_full("after_reset", 32'd1057);

    // Start and stop on the same edge.
    run_full("pre_same", 32'd100);
    stop  = 1'b1;
    do_start(32'd13);
    stop  = 1'b0;
    check("same_edge_hold", sqrt, 16'd10);
    cycles(16);
    do_stop();
    check("same_edge_result", sqrt, 16'd3);

    // Random sweep, back to back: each stop coincides with the next start.
    prev = $urandom;
    do_start(prev);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: nxt = $urandom;
        1: begin r = longint'($urandom_range(0, 65535)); nxt = W'(r * r); end
        2: begin r = longint'($urandom_range(1, 65535)); nxt = W'(r * r - 1); end
        default: begin r = longint'($urandom_range(0, 65535)); nxt = W'(r * r + 2 * r); end
      endcase
      cycles(16);
      stop = 1'b1;
      do_start(nxt);
      stop = 1'b0;
      check("sweep", sqrt, isqrt(longint'(prev)));
      prev = nxt;
    end
    cycles(16);
    do_stop();
    check("sweep_last", sqrt, isqrt(longint'(prev)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
